// File: rtl/pet_uart_tx.sv
// pet_uart_tx -- byte-wide UART transmitter with an 8-entry FIFO.
//
// Bytes written through tx_wr/tx_data are queued in an 8-deep FIFO and sent
// LSB first on txd. The default frame is 8N1 (start, 8 data bits, stop).
// Defining PET_UART_TX_PARITY_EN makes the frame 8E1 by inserting an even
// parity bit between the data bits and the stop bit.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      serial bit rate; one bit lasts CLK_FREQ/BAUD cycles (must be >= 2)
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset; aborts any frame, drops the queue
//   tx_data   byte to enqueue
//   tx_wr     write strobe, accepted only while tx_full is low
//   tx_full   FIFO holds 8 bytes (registered)
//   tx_empty  FIFO holds 0 bytes (registered)
//   tx_busy   a frame is being shifted out
//   txd       registered serial output, idle high
module pet_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PET_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO
  logic [7:0] mem [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       full_q, empty_q;
  logic       wr_acc, pop;

  // Transmitter
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign wr_acc = tx_wr & ~full_q;
  assign tick   = (div_q == DIV_LAST);

  // txd_d is the line level for the state being entered, so txd is a plain
  // flop output and changes exactly on the state boundary.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    data_d  = data_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr_q];
          state_d = S_START;
          div_d   = '0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          div_d   = '0;
          bit_d   = 3'd0;
          txd_d   = data_q[0];
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PET_UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^data_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = data_q[bit_q + 3'd1];
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
`ifdef PET_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          div_d   = '0;
          txd_d   = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          div_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty_q) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr_q];
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_acc ? 3'd1 : 3'd0);
    rd_ptr_d = rd_ptr_q + (pop ? 3'd1 : 3'd0);
    cnt_d    = cnt_q + 4'(wr_acc) - 4'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == 4'd8);
      empty_q  <= (cnt_d == 4'd0);
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr_q] <= tx_data;
  end

  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_busy  = busy_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_pet_uart_tx.sv
// Bench for pet_uart_tx at DIV=10. A queue-based line model predicts every
// output each cycle; a serial decoder recovers bytes from txd, and directed
// tests pin the model with hand-computed literals.
module tb_pet_uart_tx;
  localparam int CF  = 1000000;
  localparam int BD  = 100000;
  localparam int DIV = 10;
`ifdef PET_UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic clk = 1'b0;
  logic reset, tx_wr;
  logic [7:0] tx_data;
  logic tx_full, tx_empty, tx_busy, txd;

  pet_uart_tx #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .txd(txd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- model: FIFO of bytes + queue of future line levels
  logic [7:0] mq[$];
  logic       line[$];
  logic m_txd, m_busy, m_full, m_empty;
  bit   started = 0;
  int   m_sz;
  bit   m_pop, m_acc;
  logic [7:0] m_b;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); line.delete();
      m_txd = 1'b1; m_busy = 1'b0;
      started = 1;
    end else begin
      m_sz  = mq.size();
      m_pop = (line.size() == 0) && (m_sz > 0);
      m_acc = tx_wr && (m_sz < 8);
      if (m_pop) begin
        m_b = mq.pop_front();
        for (int i = 0; i < DIV; i++) line.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < DIV; i++) line.push_back(m_b[b]);
        if (NB == 11)
          for (int i = 0; i < DIV; i++) line.push_back(^m_b);
        for (int i = 0; i < DIV; i++) line.push_back(1'b1);
      end
      if (m_acc) mq.push_back(tx_data);
      if (line.size() > 0) begin m_txd = line.pop_front(); m_busy = 1'b1; end
      else begin m_txd = 1'b1; m_busy = 1'b0; end
    end
    m_full  = (mq.size() == 8);
    m_empty = (mq.size() == 0);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_txd",   32'(txd),      32'(m_txd));
      chk("model_busy",  32'(tx_busy),  32'(m_busy));
      chk("model_full",  32'(tx_full),  32'(m_full));
      chk("model_empty", 32'(tx_empty), 32'(m_empty));
    end
  end

  // ---------------- serial decoder, samples mid-bit
  logic [7:0] rx_q[$];
  bit   rx_act = 0;
  int   rx_t, rx_k;
  logic rx_prev = 1'b1;
  logic [7:0] rx_sh;
  logic rx_par;

  always @(negedge clk) begin
    if (reset) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (rx_prev === 1'b1 && txd === 1'b0) begin rx_act = 1; rx_t = 0; end
    end else begin
      rx_t++;
      if (rx_t % DIV == DIV / 2) begin
        rx_k = rx_t / DIV;
        if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = txd;
        if (NB == 11 && rx_k == 9) rx_par = txd;
        if (rx_k == NB - 1) begin
          chk("stop_bit", 32'(txd), 32'd1);
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
    rx_prev = txd;
  end

  task automatic chk_rx(input logic [7:0] exp[$]);
    chk("rx_count", rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk("rx_byte", 32'(rx_q[i]), 32'(exp[i]));
  endtask

  // ---------------- directed tests
  logic [10:0] pat55;
  logic [7:0]  exp_q[$];
  int n, lows;

  initial begin
`ifdef PET_UART_TX_PARITY_EN
    pat55 = 11'b10010101010;
`else
    pat55 = 11'b01010101010;
`endif
    // Reset with a write strobe held high: the write must be ignored.
    reset = 1'b1; tx_wr = 1'b1; tx_data = 8'h99;
    tick(3);
    reset = 1'b0; tx_wr = 1'b0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(tx_full), 32'd0);
    chk("rst_empty", 32'(tx_empty), 32'd1);
    tick(2);
    chk("rst_wr_ignored", 32'(tx_empty), 32'd1);
    chk("rst_idle_txd", 32'(txd), 32'd1);

    // Single byte 0x55: start low from the next edge, then the bits.
    rx_q.delete();
    tx_data = 8'h55; tx_wr = 1'b1; tick(1);
    tx_wr = 1'b0;
    chk("w55_txd_at_write", 32'(txd), 32'd1);
    for (int j = 1; j <= FRAME + 1; j++) begin
      tick(1);
      if (j == 1) chk("w55_start_edge", 32'(txd), 32'd0);
      if (j % DIV == 5) chk("w55_bit", 32'(txd), 32'(pat55[j / DIV]));
      if (j == FRAME) chk("w55_busy_last", 32'(tx_busy), 32'd1);
      if (j == FRAME + 1) chk("w55_busy_end", 32'(tx_busy), 32'd0);
    end
    exp_q = '{8'h55};
    chk_rx(exp_q);

    // Fill: a leader frame keeps the FSM busy so 0x00..0x07 fill all 8 slots.
    rx_q.delete();
    tx_data = 8'hC3; tx_wr = 1'b1; tick(1);
    tx_wr = 1'b0; tick(1);
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'(i); tx_wr = 1'b1; tick(1);
    end
    chk("fill_full", 32'(tx_full), 32'd1);
    tx_data = 8'hFF; tick(1);
    tx_wr = 1'b0;
    chk("fill_full_after_drop", 32'(tx_full), 32'd1);
    n = 0;
    while (tx_busy && n < 3000) begin tick(1); n++; end
    chk("fill_drain_len", n, 9 * FRAME - 9);
    chk("fill_empty", 32'(tx_empty), 32'd1);
    exp_q = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk_rx(exp_q);

    // Writes coinciding with pops at end of STOP.
    rx_q.delete();
    tx_data = 8'h11; tx_wr = 1'b1; tick(1);
    tx_wr = 1'b0; tick(1);
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'h20 + 8'(i); tx_wr = 1'b1; tick(1);
    end
    tx_wr = 1'b0;
    chk("pop_full", 32'(tx_full), 32'd1);
    tick(FRAME - 9);
    tx_data = 8'hEE; tx_wr = 1'b1; tick(1);   // full in this cycle: dropped
    tx_wr = 1'b0;
    chk("pop_full_after_pop", 32'(tx_full), 32'd0);
    chk("pop_empty_after_pop", 32'(tx_empty), 32'd0);
    tick(FRAME - 1);
    tx_data = 8'hBB; tx_wr = 1'b1; tick(1);   // not full: accepted with pop
    tx_wr = 1'b0;
    chk("pop_wr_full", 32'(tx_full), 32'd0);
    n = 0;
    while (tx_busy && n < 3000) begin tick(1); n++; end
    chk("pop_drain_len", n, 8 * FRAME);
    chk("pop_drain_empty", 32'(tx_empty), 32'd1);
    exp_q = '{8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hBB};
    chk_rx(exp_q);

    // Reset during data bit 3 of 0xA5 with 3 bytes queued.
    rx_q.delete();
    tx_data = 8'hA5; tx_wr = 1'b1; tick(1);
    tx_data = 8'h01; tick(1);
    tx_data = 8'h02; tick(1);
    tx_data = 8'h03; tick(1);
    tx_wr = 1'b0;
    tick(41);
    chk("abort_bit3", 32'(txd), 32'd0);
    reset = 1'b1; tx_wr = 1'b1; tx_data = 8'h99; tick(1);
    reset = 1'b0; tx_wr = 1'b0;
    chk("abort_txd", 32'(txd), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_empty", 32'(tx_empty), 32'd1);
    chk("abort_full", 32'(tx_full), 32'd0);
    lows = 0;
    for (int j = 0; j < 3 * FRAME; j++) begin
      tick(1);
      if (txd !== 1'b1) lows++;
    end
    chk("abort_no_frames", lows, 0);
    chk("abort_rx", rx_q.size(), 0);

`ifdef PET_UART_TX_PARITY_EN
    rx_q.delete();
    tx_data = 8'h07; tx_wr = 1'b1; tick(1);
    tx_wr = 1'b0; tick(1); n = 1;
    while (tx_busy && n < 1000) begin tick(1); n++; end
    chk("par07_len", n, 111);
    chk("par07_bit", 32'(rx_par), 32'd1);
    tx_data = 8'h03; tx_wr = 1'b1; tick(1);
    tx_wr = 1'b0; tick(1); n = 1;
    while (tx_busy && n < 1000) begin tick(1); n++; end
    chk("par03_bit", 32'(rx_par), 32'd0);
    exp_q = '{8'h07, 8'h03};
    chk_rx(exp_q);
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
